pipeline_control_unit: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. It consumes the decode-stage load-use hazard flag, the branch-taken decision and the data-memory busy signal, and drives the write enables, flush and bubble controls of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB. It also tracks multi-cycle branch flush windows, memory-freeze timeouts and saturating performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_control_unit_if.sv | 33 +++
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_control_unit.sv | 126 ++++++++++++
 tb/tb_pipeline_control_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline stall/flush controller.
// Imported by the controller top and the performance counters.
package pipeline_ctrl_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;

  typedef enum logic [1:0] {
    S_RUN    = RUN,
    S_FLUSH  = FLUSH,
    S_FREEZE = FREEZE
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard inputs and stage-control outputs of the pipeline controller.
// master = hazard sources / pipeline side, slave = controller.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             br_taken;
  logic             mem_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_exe_bubble;
  logic             exe_mem_en;
  logic             mem_wb_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output hazard_detected, br_taken, mem_busy,
    input  pc_en, if_id_en, if_id_flush,
    input  id_exe_bubble, exe_mem_en, mem_wb_en,
    input  mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  hazard_detected, br_taken, mem_busy,
    output pc_en, if_id_en, if_id_flush,
    output id_exe_bubble, exe_mem_en, mem_wb_en,
    output mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAXV = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), 32'(MAXV)));
    end
  end
endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush controller for the five-stage pipeline: freeze on
// memory busy, bubble on load-use, squash wrong-path fetches.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst,
  pipeline_control_unit_if.slave ctl
);
  localparam logic [2:0]  FL_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO     = 16'(TIMEOUT);

  state_t      state;
  state_t      state_nx;
  state_t      eff;
  logic [2:0]  flush_left;
  logic [2:0]  fl_nx;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        timeout_q;

  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_exe_bubble;
  logic exe_mem_en;
  logic mem_wb_en;
  logic frozen;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    exe_mem_en    = 1'b1;
    mem_wb_en     = 1'b1;
    frozen        = 1'b0;
    state_nx      = state;
    fl_nx         = flush_left;
    wait_inc      = 16'(sat_inc(32'(wait_cnt), 32'hFFFF));
    // the cycle after a freeze ends behaves as the state it resumes
    eff = state;
    if (state == S_FREEZE) begin
      eff = (flush_left != 3'd0) ? S_FLUSH : S_RUN;
    end
    if (rst) begin
      if (ctl.mem_busy) begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        exe_mem_en = 1'b0;
        mem_wb_en  = 1'b0;
        frozen     = 1'b1;
        state_nx   = S_FREEZE;
      end else if (ctl.hazard_detected) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_bubble = 1'b1;
        if_id_flush   = (eff == S_FLUSH);
        state_nx      = eff;
      end else if (eff == S_FLUSH) begin
        if_id_flush = 1'b1;
        fl_nx       = flush_left - 3'd1;
        state_nx    = (flush_left == 3'd1) ? S_RUN : S_FLUSH;
      end else if (ctl.br_taken) begin
        if_id_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          fl_nx    = FL_LOAD;
          state_nx = S_FLUSH;
        end else begin
          state_nx = S_RUN;
        end
      end else begin
        state_nx = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      flush_left <= 3'd0;
      wait_cnt   <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      flush_left <= fl_nx;
      wait_cnt   <= frozen ? wait_inc : 16'd0;
      if (frozen && wait_inc >= TMO) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign ctl.pc_en         = pc_en;
  assign ctl.if_id_en      = if_id_en;
  assign ctl.if_id_flush   = if_id_flush;
  assign ctl.id_exe_bubble = id_exe_bubble;
  assign ctl.exe_mem_en    = exe_mem_en;
  assign ctl.mem_wb_en     = mem_wb_en;
  assign ctl.mem_timeout   = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (id_exe_bubble),
    .q   (ctl.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk (clk),
    .rst (rst),
    .inc (if_id_flush),
    .q   (ctl.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze (
    .clk (clk),
    .rst (rst),
    .inc (frozen),
    .q   (ctl.freeze_cnt)
  );
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed scoreboard bench for pipeline_control_unit
// (FLUSH_CYCLES=3, TIMEOUT=4).
module tb_pipeline_control_unit;
  typedef struct packed {
    logic [5:0]  c;
    logic        t;
    logic [15:0] s;
    logic [15:0] f;
    logic [15:0] z;
  } exp_t;

  // {pc_en, if_id_en, if_id_flush, id_exe_bubble, exe_mem_en, mem_wb_en}
  localparam logic [5:0] O_RUN = 6'b110011;
  localparam logic [5:0] O_HZ  = 6'b000111;
  localparam logic [5:0] O_FL  = 6'b111011;
  localparam logic [5:0] O_HZF = 6'b001111;
  localparam logic [5:0] O_FRZ = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(16)) bus ();

  pipeline_control_unit #(
    .FLUSH_CYCLES (3),
    .TIMEOUT      (4),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.slave)
  );

  task automatic step(
    input logic r, input logic hz, input logic br, input logic bz,
    input logic [5:0] c, input logic t,
    input int s, input int f, input int z, input string nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.hazard_detected = hz;
    bus.br_taken = br;
    bus.mem_busy = bz;
    e.c = c;
    e.t = t;
    e.s = 16'(s);
    e.f = 16'(f);
    e.z = 16'(z);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a.c = {bus.pc_en, bus.if_id_en, bus.if_id_flush,
             bus.id_exe_bubble, bus.exe_mem_en, bus.mem_wb_en};
      a.t = bus.mem_timeout;
      a.s = bus.stall_cnt;
      a.f = bus.flush_cnt;
      a.z = bus.freeze_cnt;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s: got ctl=%b tmo=%b st=%0d fl=%0d fz=%0d, want ctl=%b tmo=%b st=%0d fl=%0d fz=%0d",
                 nm, a.c, a.t, a.s, a.f, a.z, e.c, e.t, e.s, e.f, e.z);
      end
    end
  end

  initial begin
    int guard;
    bus.hazard_detected = 1'b0;
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;
    // reset: outputs forced to run values even with busy asserted
    step(0, 0, 0, 0, O_RUN, 0, 0, 0, 0, "rst_idle");
    step(0, 0, 0, 1, O_RUN, 0, 0, 0, 0, "rst_busy");
    step(1, 0, 0, 0, O_RUN, 0, 0, 0, 0, "rel_idle");
    // single hazard
    step(1, 1, 0, 0, O_HZ,  0, 0, 0, 0, "hz");
    step(1, 0, 0, 0, O_RUN, 0, 1, 0, 0, "hz_after");
    // three-cycle branch flush
    step(1, 0, 1, 0, O_FL,  0, 1, 0, 0, "br1_c0");
    step(1, 0, 0, 0, O_FL,  0, 1, 1, 0, "br1_c1");
    step(1, 0, 0, 0, O_FL,  0, 1, 2, 0, "br1_c2");
    step(1, 0, 0, 0, O_RUN, 0, 1, 3, 0, "br1_end");
    // hazard in second flush cycle stretches window
    step(1, 0, 1, 0, O_FL,  0, 1, 3, 0, "br2_c0");
    step(1, 1, 0, 0, O_HZF, 0, 1, 4, 0, "br2_hz");
    step(1, 0, 0, 0, O_FL,  0, 2, 5, 0, "br2_c2");
    step(1, 0, 0, 0, O_FL,  0, 2, 6, 0, "br2_c3");
    step(1, 0, 0, 0, O_RUN, 0, 2, 7, 0, "br2_end");
    // branch inside flush window is ignored
    step(1, 0, 1, 0, O_FL,  0, 2, 7, 0, "br3_c0");
    step(1, 0, 1, 0, O_FL,  0, 2, 8, 0, "br3_ign");
    step(1, 0, 0, 0, O_FL,  0, 2, 9, 0, "br3_c2");
    step(1, 0, 0, 0, O_RUN, 0, 2, 10, 0, "br3_end");
    // simultaneous events and freeze timeout
    step(1, 1, 1, 0, O_HZ,  0, 2, 10, 0, "hz_br");
    step(1, 1, 1, 1, O_FRZ, 0, 3, 10, 0, "all3");
    step(1, 0, 0, 1, O_FRZ, 0, 3, 10, 1, "frz2");
    step(1, 0, 0, 1, O_FRZ, 0, 3, 10, 2, "frz3");
    step(1, 0, 0, 1, O_FRZ, 0, 3, 10, 3, "frz4");
    step(1, 0, 0, 0, O_RUN, 1, 3, 10, 4, "frz_exit");
    step(1, 0, 0, 0, O_RUN, 1, 3, 10, 4, "tmo_sticky");
    // freeze inside flush resumes the flush
    step(1, 0, 1, 0, O_FL,  1, 3, 10, 4, "br4_c0");
    step(1, 0, 0, 1, O_FRZ, 1, 3, 11, 4, "br4_frz");
    step(1, 0, 0, 0, O_FL,  1, 3, 11, 5, "br4_resume");
    // async reset mid-flush
    step(0, 0, 0, 0, O_RUN, 0, 0, 0, 0, "rst_mid");
    step(1, 0, 0, 0, O_RUN, 0, 0, 0, 0, "post_rst1");
    step(1, 0, 0, 0, O_RUN, 0, 0, 0, 0, "post_rst2");
    // wait counter clears between separate freezes
    step(1, 0, 0, 1, O_FRZ, 0, 0, 0, 0, "wc_a1");
    step(1, 0, 0, 1, O_FRZ, 0, 0, 0, 1, "wc_a2");
    step(1, 0, 0, 0, O_RUN, 0, 0, 0, 2, "wc_gap");
    step(1, 0, 0, 1, O_FRZ, 0, 0, 0, 2, "wc_b1");
    step(1, 0, 0, 1, O_FRZ, 0, 0, 0, 3, "wc_b2");
    step(1, 0, 0, 0, O_RUN, 0, 0, 0, 4, "wc_end");
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
